// File: rtl/buffer_sequencer_pkg.sv
// Shared types and default sizing for the buffer sequencer.
// Holds the job-state enumeration and the default counter/timeout constants.
package buffer_sequencer_pkg;

    localparam int unsigned DEF_RD_CNT_W    = 8;
    localparam int unsigned DEF_STALL_LIMIT = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } seq_state_e;

endpackage : buffer_sequencer_pkg

// File: rtl/buffer_sequencer_stall_timer.sv
// Counts consecutive RUN cycles without a buffer read and raises a sticky
// error once the count reaches LIMIT; only a new job (restart) or reset clears it.
module buffer_sequencer_stall_timer #(
    parameter int unsigned LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic clear,
    input  logic restart,
    output logic stall_err
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             err_q;
    logic             err_d;

    // Counter saturates at LIMIT so a long stall cannot wrap it back to zero.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (clear) begin
            cnt_d = '0;
        end else if (tick && (cnt_q != CNT_W'(LIMIT))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (restart) begin
            err_d = 1'b0;
        end else if (!clear && tick && (cnt_q == CNT_W'(LIMIT - 1))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign stall_err = err_q;

endmodule : buffer_sequencer_stall_timer

// File: rtl/buffer_sequencer.sv
// Sequences the write/read strobes of a circular buffer for one job of
// cfg_rounds read beats, with done pulse, abort and stall detection.
module buffer_sequencer
    import buffer_sequencer_pkg::*;
#(
    parameter int unsigned RD_CNT_W    = DEF_RD_CNT_W,
    parameter int unsigned STALL_LIMIT = DEF_STALL_LIMIT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [RD_CNT_W-1:0] cfg_rounds,
    input  logic                src_valid,
    output logic                src_ready,
    input  logic                buf_ready,
    input  logic                buf_valid,
    input  logic                buf_full,
    input  logic                buf_empty,
    output logic                buf_write_en,
    output logic                buf_read_en,
    input  logic                mac_ready,
    output logic                mac_valid,
    output logic                busy,
    output logic                done,
    output logic                stall_err,
    output logic [RD_CNT_W-1:0] rd_count
);

    seq_state_e          state_q;
    seq_state_e          state_d;
    logic [RD_CNT_W-1:0] rounds_q;
    logic [RD_CNT_W-1:0] rounds_d;
    logic [RD_CNT_W-1:0] rd_count_q;
    logic [RD_CNT_W-1:0] rd_count_d;
    logic                done_q;
    logic                busy_q;
    logic                mac_valid_q;

    logic                in_run;
    logic                wr_ok;
    logic                rd_ok;
    logic                start_acc;

    // Buffer strobes are combinational from the registered state, so they
    // drop to zero the moment reset forces the state back to idle.
    assign in_run    = (state_q == ST_RUN);
    assign wr_ok     = in_run & src_valid & buf_ready & ~buf_full;
    assign rd_ok     = in_run & buf_valid & ~buf_empty & mac_ready & (rd_count_q < rounds_q);
    assign start_acc = (state_q == ST_IDLE) & start;

    assign src_ready    = wr_ok;
    assign buf_write_en = wr_ok;
    assign buf_read_en  = rd_ok;

    // Next-state logic; abort outranks the read bookkeeping in RUN.
    always_comb begin
        state_d    = state_q;
        rounds_d   = rounds_q;
        rd_count_d = rd_count_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rounds_d   = cfg_rounds;
                    rd_count_d = '0;
                    state_d    = (cfg_rounds == '0) ? ST_FINISH : ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d    = ST_IDLE;
                    rd_count_d = '0;
                end else if (rd_ok) begin
                    rd_count_d = rd_count_q + RD_CNT_W'(1);
                    if ((rd_count_q + RD_CNT_W'(1)) == rounds_q) begin
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
                if (abort) begin
                    rd_count_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            rounds_q    <= '0;
            rd_count_q  <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            mac_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rounds_q    <= rounds_d;
            rd_count_q  <= rd_count_d;
            done_q      <= (state_d == ST_FINISH);
            busy_q      <= (state_d != ST_IDLE);
            mac_valid_q <= rd_ok;
        end
    end

    buffer_sequencer_stall_timer #(
        .LIMIT (STALL_LIMIT)
    ) u_stall_timer (
        .clk       (clk),
        .rst       (rst),
        .tick      (in_run & ~rd_ok),
        .clear     (~in_run | rd_ok),
        .restart   (start_acc),
        .stall_err (stall_err)
    );

    assign done      = done_q;
    assign busy      = busy_q;
    assign mac_valid = mac_valid_q;
    assign rd_count  = rd_count_q;

endmodule : buffer_sequencer

// File: tb/tb_buffer_sequencer.sv
// Scoreboard bench for buffer_sequencer: a job-level reference model queues the
// expected outputs of every cycle and an independent monitor checks them.
module tb_buffer_sequencer;

    localparam int unsigned RW  = 8;
    localparam int          LIM = 64;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic [RW-1:0] cfg_rounds;
    logic          src_valid;
    logic          src_ready;
    logic          buf_ready;
    logic          buf_valid;
    logic          buf_full;
    logic          buf_empty;
    logic          buf_write_en;
    logic          buf_read_en;
    logic          mac_ready;
    logic          mac_valid;
    logic          busy;
    logic          done;
    logic          stall_err;
    logic [RW-1:0] rd_count;

    buffer_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .cfg_rounds   (cfg_rounds),
        .src_valid    (src_valid),
        .src_ready    (src_ready),
        .buf_ready    (buf_ready),
        .buf_valid    (buf_valid),
        .buf_full     (buf_full),
        .buf_empty    (buf_empty),
        .buf_write_en (buf_write_en),
        .buf_read_en  (buf_read_en),
        .mac_ready    (mac_ready),
        .mac_valid    (mac_valid),
        .busy         (busy),
        .done         (done),
        .stall_err    (stall_err),
        .rd_count     (rd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          src_ready;
        logic          buf_write_en;
        logic          buf_read_en;
        logic          mac_valid;
        logic          busy;
        logic          done;
        logic          stall_err;
        logic [RW-1:0] rd_count;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Job-level reference: is a job open, has it reached its done cycle,
    // how many reads it wants and has had, and the stall history.
    bit m_job;
    bit m_fin;
    bit m_mac;
    bit m_err;
    int m_rounds;
    int m_reads;
    int m_stall;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_job = 0; m_fin = 0; m_mac = 0; m_err = 0;
        m_rounds = 0; m_reads = 0; m_stall = 0;
    endtask

    // Drive one cycle of inputs, queue what the outputs must show, advance the model.
    task automatic step(input bit st, input bit ab, input int cfg, input bit sv,
                        input bit br, input bit bv, input bit bf, input bit be,
                        input bit mr);
        obs_t e;
        bit   running;
        @(posedge clk);
        #1;
        start = st; abort = ab; cfg_rounds = RW'(cfg);
        src_valid = sv; buf_ready = br; buf_valid = bv;
        buf_full = bf; buf_empty = be; mac_ready = mr;

        running        = m_job && !m_fin;
        e.src_ready    = running && sv && br && !bf;
        e.buf_write_en = e.src_ready;
        e.buf_read_en  = running && bv && !be && mr && (m_reads < m_rounds);
        e.mac_valid    = m_mac;
        e.busy         = m_job;
        e.done         = m_fin;
        e.stall_err    = m_err;
        e.rd_count     = RW'(m_reads);
        exp_q.push_back(e);

        m_mac = e.buf_read_en;
        if (running) begin
            if (e.buf_read_en) m_stall = 0;
            else begin
                m_stall++;
                if (m_stall >= LIM) m_err = 1;
            end
        end else begin
            m_stall = 0;
        end

        if (!m_job) begin
            if (st) begin
                m_job = 1; m_fin = (cfg == 0); m_rounds = cfg;
                m_reads = 0; m_err = 0; m_stall = 0;
            end
        end else if (ab) begin
            m_job = 0; m_fin = 0; m_reads = 0;
        end else if (m_fin) begin
            m_job = 0; m_fin = 0;
        end else if (e.buf_read_en) begin
            m_reads++;
            if (m_reads == m_rounds) m_fin = 1;
        end
    endtask

    task automatic idle_steps(input int n, input bit sv, input bit br, input bit bv,
                              input bit bf, input bit be, input bit mr);
        for (int i = 0; i < n; i++) step(0, 0, 0, sv, br, bv, bf, be, mr);
    endtask

    // Monitor: pops one expectation per cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                obs_t e;
                e = exp_q.pop_front();
                chk("src_ready",    int'(src_ready),    int'(e.src_ready));
                chk("buf_write_en", int'(buf_write_en), int'(e.buf_write_en));
                chk("buf_read_en",  int'(buf_read_en),  int'(e.buf_read_en));
                chk("mac_valid",    int'(mac_valid),    int'(e.mac_valid));
                chk("busy",         int'(busy),         int'(e.busy));
                chk("done",         int'(done),         int'(e.done));
                chk("stall_err",    int'(stall_err),    int'(e.stall_err));
                chk("rd_count",     int'(rd_count),     int'(e.rd_count));
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},      int'(busy),         0);
        chk({tag, "_done"},      int'(done),         0);
        chk({tag, "_mac_valid"}, int'(mac_valid),    0);
        chk({tag, "_stall_err"}, int'(stall_err),    0);
        chk({tag, "_rd_count"},  int'(rd_count),     0);
        chk({tag, "_src_ready"}, int'(src_ready),    0);
        chk({tag, "_wr_en"},     int'(buf_write_en), 0);
        chk({tag, "_rd_en"},     int'(buf_read_en),  0);
    endtask

    initial begin
        rst = 1'b0; start = 0; abort = 0; cfg_rounds = '0;
        src_valid = 0; buf_ready = 0; buf_valid = 0;
        buf_full = 0; buf_empty = 0; mac_ready = 0;
        model_reset();
        #1;
        check_all_zero("reset");
        #21 rst = 1'b1;

        // Four-round job with an always-ready buffer and consumer.
        step(1, 0, 4, 1, 1, 1, 0, 0, 1);
        idle_steps(7, 1, 1, 1, 0, 0, 1);

        // Zero-round job goes straight to its done cycle.
        step(1, 0, 0, 1, 1, 1, 0, 0, 1);
        idle_steps(3, 1, 1, 1, 0, 0, 1);

        // Full buffer blocks writes until it drains; job then aborted.
        step(1, 0, 3, 1, 1, 0, 1, 0, 1);
        idle_steps(3, 1, 1, 0, 1, 0, 1);
        idle_steps(2, 1, 1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 1, 0, 0, 0, 1);
        idle_steps(2, 0, 1, 0, 0, 0, 1);

        // Consumer stalls past the limit; a start mid-job must be ignored.
        step(1, 0, 5, 0, 1, 1, 0, 0, 0);
        idle_steps(70, 0, 1, 1, 0, 0, 0);
        step(1, 0, 9, 0, 1, 1, 0, 0, 0);
        idle_steps(10, 0, 1, 1, 0, 0, 1);
        step(1, 0, 2, 0, 1, 1, 0, 0, 1);
        idle_steps(5, 0, 1, 1, 0, 0, 1);

        // Abort after two of five reads, with start/abort collision in idle.
        step(1, 0, 5, 0, 1, 1, 0, 0, 1);
        idle_steps(2, 0, 1, 1, 0, 0, 1);
        step(0, 1, 0, 0, 1, 1, 0, 0, 1);
        idle_steps(2, 0, 1, 1, 0, 0, 1);
        step(1, 1, 2, 0, 1, 1, 0, 0, 1);
        idle_steps(4, 0, 1, 1, 0, 0, 1);

        // Asynchronous reset in the middle of a job.
        step(1, 0, 6, 1, 1, 1, 0, 0, 0);
        idle_steps(3, 1, 1, 1, 0, 0, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        exp_q.delete();
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        step(1, 0, 3, 1, 1, 1, 0, 0, 1);
        idle_steps(6, 1, 1, 1, 0, 0, 1);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            bit st, ab, sv, br, bv, bf, be, mr;
            int cfg;
            st  = ($urandom_range(0, 7) == 0);
            ab  = ($urandom_range(0, 39) == 0);
            cfg = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 255))
                                               : int'($urandom_range(0, 6));
            sv  = 1'($urandom_range(0, 1));
            br  = ($urandom_range(0, 3) != 0);
            bv  = ($urandom_range(0, 3) != 0);
            bf  = ($urandom_range(0, 3) == 0);
            be  = ($urandom_range(0, 4) == 0);
            mr  = ((i / 200) % 4 == 3) ? 1'b0 : ($urandom_range(0, 3) != 0);
            step(st, ab, cfg, sv, br, bv, bf, be, mr);
        end

        repeat (2) @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_buffer_sequencer
